sync_line_fifo: RTL and testbench
=================================

Name: sync_line_fifo

Overview:
- Single-clock, parametrised FIFO for buffering cache-line strings between the cache controller and the memory-side write-back/refill path.
- Successor to the dual-clock line FIFO, for same-domain buffering: generalised width and depth, exact occupancy count, programmable almost-full/almost-empty flags, synchronous flush, sticky overflow/underflow error flags.

Parameters:
- DATA_WIDTH, 64, width of one stored entry (cache string) in bits.
- ADDR_WIDTH, 2, pointer width in bits; must be >= 1.
- FIFO_DEPTH, (1 << ADDR_WIDTH), number of entries; always a power of two.
- AFULL_LEVEL, FIFO_DEPTH-1, almost_full asserted when count >= AFULL_LEVEL.
- AEMPTY_LEVEL, 1, almost_empty asserted when count <= AEMPTY_LEVEL.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- not_reset  input  1  asynchronous, active-low reset.
- din  input  DATA_WIDTH  write data.
- write  input  1  write request.
- read  input  1  read request.
- flush  input  1  synchronous clear of contents.
- clr_err  input  1  clears the sticky error flags.
- dout  output  DATA_WIDTH  read data.
- empty  output  1  count == 0.
- full  output  1  count == FIFO_DEPTH.
- almost_empty  output  1  count <= AEMPTY_LEVEL.
- almost_full  output  1  count >= AFULL_LEVEL.
- count  output  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.

Behaviour:
- Reset (not_reset low, asynchronous):
  - wr_ptr, rd_ptr and count are 0; every memory word is 0.
  - dout = 0, overflow = 0, underflow = 0.
  - Resulting flags: empty = 1, full = 0, almost_empty = 1, almost_full = (AFULL_LEVEL == 0).
  - Reset asserted mid-operation discards all contents immediately.
- Flag derivation: all flags are combinational decodes of the registered count; there are no other flag registers.
- Read-side gate: rd_acc = read & ~empty.
- Write-side gate: wr_acc = write & (~full | rd_acc). A write on a full FIFO is accepted only if a read is accepted in the same cycle.
- On wr_acc: mem[wr_ptr] <= din; wr_ptr increments and wraps modulo FIFO_DEPTH.
- On rd_acc: dout <= mem[rd_ptr]; rd_ptr increments and wraps. Read data therefore appears one cycle after the read edge.
- Without rd_acc, dout holds its value.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither occur.
- Empty with write and read asserted together: the write is accepted, the read is rejected (no bypass), and underflow is set. Next cycle count = 1.
- Full with write and read asserted together: both are accepted, count stays FIFO_DEPTH, no overflow.
- overflow is set on a cycle where write & ~wr_acc; underflow is set on a cycle where read & ~rd_acc. Both hold until clr_err or reset.
- If clr_err and a new error occur in the same cycle, the new error wins and the flag stays 1.
- flush (priority over read and write in that cycle):
  - wr_ptr, rd_ptr and count go to 0.
  - The read and write requests of that cycle are ignored and do not set error flags.
  - Memory contents and dout are unchanged.

Optional Feature:
- Macro: SYNC_LINE_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - dout = mem[rd_ptr] combinationally and is valid whenever empty = 0.
  - read acts as an acknowledge/pop; the next entry appears in the same cycle the pointer advances.
  - After reset dout = 0, since mem is 0.
- Undefined: the registered read described in Behaviour, with one-cycle latency.
- Count, flags, flush and error behaviour are identical in both modes.

Test Plan (DATA_WIDTH=64, ADDR_WIDTH=2, defaults):
- Reset release, then idle -> dout=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
- Write 0xA0,0xA1,0xA2,0xA3 in 4 cycles:
  - After the 3rd write, almost_full=1 and count=3; after the 4th, full=1 and count=4.
  - A 5th write of 0xA4 -> rejected, overflow=1, count=4.
  - Four reads -> dout 0xA0..0xA3, each one cycle after its read edge.
- FIFO full (count=4), write 0xB0 and read in the same cycle -> count stays 4, overflow stays 0. Drain of 4 reads returns the old 2nd..4th entries, then 0xB0.
- FIFO empty, write 0xC0 and read in the same cycle -> count=1, underflow=1, dout unchanged. Pulse clr_err -> underflow=0.
- Write 3 entries, assert flush with write 0xD0 -> count=0, empty=1, no error flags set. A subsequent read sets underflow=1.
- Wrap test: 10 cycles of continuous one-write/one-read with 0x100+i after a single pre-fill write -> dout sequence is exactly in order with no loss. With SYNC_LINE_FIFO_FWFT_EN, the head is visible on dout while empty=0 and before any read.

Source files
------------

// File: rtl/sync_line_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : sync_line_fifo                                              |
// | Brief    : Single-clock line FIFO with occupancy count, programmable   |
// |            almost flags, synchronous flush and sticky error flags.     |
// |            Define SYNC_LINE_FIFO_FWFT_EN for first-word-fall-through.  |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module sync_line_fifo #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 2,
  parameter int FIFO_DEPTH   = (1 << ADDR_WIDTH),
  parameter int AFULL_LEVEL  = FIFO_DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  not_reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  write,
  input  logic                  read,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] c_depth        = FIFO_DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] c_afull_level  = AFULL_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] c_aempty_level = AEMPTY_LEVEL[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_rd_acc;
  logic w_wr_acc;
  logic w_ovf_evt;
  logic w_udf_evt;

  // All flags decode the registered count; there are no separate flag registers.
  assign empty        = (r_count == '0);
  assign full         = (r_count == c_depth);
  assign almost_empty = (r_count <= c_aempty_level);
  assign almost_full  = (r_count >= c_afull_level);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // A flush cycle swallows both requests without flagging errors.
  assign w_rd_acc  = read & ~empty & ~flush;
  assign w_wr_acc  = write & (~full | w_rd_acc) & ~flush;
  assign w_ovf_evt = write & ~w_wr_acc & ~flush;
  assign w_udf_evt = read & ~w_rd_acc & ~flush;

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (r_overflow  & ~clr_err) | w_ovf_evt;
      r_underflow <= (r_underflow & ~clr_err) | w_udf_evt;
    end
  end

`ifdef SYNC_LINE_FIFO_FWFT_EN
  assign dout = r_mem[r_rd_ptr];
`else
  logic [DATA_WIDTH-1:0] r_dout;

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      r_dout <= '0;
    end else if (w_rd_acc) begin
      r_dout <= r_mem[r_rd_ptr];
    end
  end

  assign dout = r_dout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_line_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_sync_line_fifo                                           |
// | Brief    : Directed self-checking bench for sync_line_fifo (registered |
// |            read mode, default parameters).                             |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module tb_sync_line_fifo;

  logic        clk;
  logic        not_reset;
  logic [63:0] din;
  logic        write;
  logic        read;
  logic        flush;
  logic        clr_err;
  logic [63:0] dout;
  logic        empty;
  logic        full;
  logic        almost_empty;
  logic        almost_full;
  logic [2:0]  count;
  logic        overflow;
  logic        underflow;

  int n_cmp = 0;
  int n_err = 0;

  sync_line_fifo dut (
    .clk          (clk),
    .not_reset    (not_reset),
    .din          (din),
    .write        (write),
    .read         (read),
    .flush        (flush),
    .clr_err      (clr_err),
    .dout         (dout),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [2:0] c, input logic e,
                             input logic f, input logic ae, input logic af);
    check({tag, ".count"}, {61'd0, count}, {61'd0, c});
    check({tag, ".empty"}, {63'd0, empty}, {63'd0, e});
    check({tag, ".full"}, {63'd0, full}, {63'd0, f});
    check({tag, ".aempty"}, {63'd0, almost_empty}, {63'd0, ae});
    check({tag, ".afull"}, {63'd0, almost_full}, {63'd0, af});
  endtask

  initial begin
    not_reset = 1'b0;
    din       = '0;
    write     = 1'b0;
    read      = 1'b0;
    flush     = 1'b0;
    clr_err   = 1'b0;
    tick();
    tick();
    not_reset = 1'b1;
    tick();

    // Reset state
    check("rst.dout", dout, 64'h0);
    check_flags("rst", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("rst.ovf", {63'd0, overflow}, 64'd0);
    check("rst.udf", {63'd0, underflow}, 64'd0);

    // Fill with A0..A3
    write = 1'b1;
    din = 64'hA0; tick(); check_flags("w1", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    din = 64'hA1; tick(); check_flags("w2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    din = 64'hA2; tick(); check_flags("w3", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    din = 64'hA3; tick(); check_flags("w4", 3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
    din = 64'hA4; tick();
    check("ovf.set", {63'd0, overflow}, 64'd1);
    check("ovf.count", {61'd0, count}, 64'd4);
    write = 1'b0;

    // Drain: data one cycle after the read edge
    read = 1'b1;
    tick(); check("r1.dout", dout, 64'hA0); check("r1.count", {61'd0, count}, 64'd3);
    tick(); check("r2.dout", dout, 64'hA1);
    tick(); check("r3.dout", dout, 64'hA2);
    tick(); check("r4.dout", dout, 64'hA3); check_flags("r4", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    read = 1'b0;
    tick(); check("hold.dout", dout, 64'hA3);
    check("ovf.sticky", {63'd0, overflow}, 64'd1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("ovf.clr", {63'd0, overflow}, 64'd0);

    // Full with simultaneous write and read
    write = 1'b1;
    din = 64'hE0; tick();
    din = 64'hE1; tick();
    din = 64'hE2; tick();
    din = 64'hE3; tick();
    check("fill.count", {61'd0, count}, 64'd4);
    din = 64'hB0; read = 1'b1; tick();
    write = 1'b0;
    check("fullrw.count", {61'd0, count}, 64'd4);
    check("fullrw.ovf", {63'd0, overflow}, 64'd0);
    check("fullrw.dout", dout, 64'hE0);
    tick(); check("d1.dout", dout, 64'hE1);
    tick(); check("d2.dout", dout, 64'hE2);
    tick(); check("d3.dout", dout, 64'hE3);
    tick(); check("d4.dout", dout, 64'hB0);
    read = 1'b0;
    check("d4.empty", {63'd0, empty}, 64'd1);

    // Empty with simultaneous write and read
    write = 1'b1; read = 1'b1; din = 64'hC0; tick();
    write = 1'b0; read = 1'b0;
    check("emptyrw.count", {61'd0, count}, 64'd1);
    check("emptyrw.udf", {63'd0, underflow}, 64'd1);
    check("emptyrw.dout", dout, 64'hB0);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("udf.clr", {63'd0, underflow}, 64'd0);

    // Flush wins over a concurrent write
    write = 1'b1;
    din = 64'hD1; tick();
    din = 64'hD2; tick();
    din = 64'hD3; tick();
    check("preflush.count", {61'd0, count}, 64'd4);
    flush = 1'b1; din = 64'hD0; tick();
    flush = 1'b0; write = 1'b0;
    check_flags("flush", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("flush.ovf", {63'd0, overflow}, 64'd0);
    check("flush.udf", {63'd0, underflow}, 64'd0);
    check("flush.dout", dout, 64'hB0);
    read = 1'b1; tick(); read = 1'b0;
    check("postflush.udf", {63'd0, underflow}, 64'd1);
    check("postflush.dout", dout, 64'hB0);
    clr_err = 1'b1; tick(); clr_err = 1'b0;

    // Wrap: continuous write+read after one pre-fill entry
    write = 1'b1; din = 64'hFF; tick();
    read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din = 64'h100 + 64'(i);
      tick();
      check($sformatf("wrap%0d.dout", i), dout, (i == 0) ? 64'hFF : 64'h100 + 64'(i - 1));
      check($sformatf("wrap%0d.count", i), {61'd0, count}, 64'd1);
    end
    write = 1'b0;
    tick();
    read = 1'b0;
    check("wrap.last", dout, 64'h109);
    check("wrap.empty", {63'd0, empty}, 64'd1);
    check("wrap.errs", {62'd0, overflow, underflow}, 64'd0);

    // Asynchronous reset mid-operation
    write = 1'b1; din = 64'h55; tick(); write = 1'b0;
    check("prerst.count", {61'd0, count}, 64'd1);
    #2 not_reset = 1'b0;
    #1;
    check("arst.count", {61'd0, count}, 64'd0);
    check("arst.dout", dout, 64'h0);
    check("arst.empty", {63'd0, empty}, 64'd1);
    tick();
    not_reset = 1'b1;
    tick();
    read = 1'b1; tick(); read = 1'b0;
    check("arst.udf", {63'd0, underflow}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
